// File: rtl/cpu_ctrl_pkg.sv
// Shared definitions for the hardwired CPU control unit: opcodes, ALU codes,
// T-state encoding, IR field positions and the strobe bundle.
package cpu_ctrl_pkg;

   localparam int OPC_HI = 31;
   localparam int OPC_LO = 27;
   localparam int RA_HI  = 26;
   localparam int RA_LO  = 23;
   localparam int RB_HI  = 22;
   localparam int RB_LO  = 19;
   localparam int RC_HI  = 18;
   localparam int RC_LO  = 15;
   localparam int C_HI   = 18;
   localparam int C_LO   = 0;

   localparam logic [4:0] OP_LD   = 5'b00000;
   localparam logic [4:0] OP_LDI  = 5'b00001;
   localparam logic [4:0] OP_ST   = 5'b00010;
   localparam logic [4:0] OP_ADD  = 5'b00011;
   localparam logic [4:0] OP_OR   = 5'b01010;
   localparam logic [4:0] OP_ADDI = 5'b01011;
   localparam logic [4:0] OP_ANDI = 5'b01100;
   localparam logic [4:0] OP_ORI  = 5'b01101;
   localparam logic [4:0] OP_NOP  = 5'b11010;
   localparam logic [4:0] OP_HALT = 5'b11011;

   localparam logic [4:0] ALU_NONE = 5'b00000;
   localparam logic [4:0] ALU_ADD  = 5'b00011;
   localparam logic [4:0] ALU_AND  = 5'b01001;
   localparam logic [4:0] ALU_OR   = 5'b01010;

   typedef enum logic [3:0] {
      ST_RST  = 4'd0,
      ST_T0   = 4'd1,
      ST_T1   = 4'd2,
      ST_T1W  = 4'd3,
      ST_T2   = 4'd4,
      ST_T3   = 4'd5,
      ST_T4   = 4'd6,
      ST_T5   = 4'd7,
      ST_T6   = 4'd8,
      ST_T7   = 4'd9,
      ST_HALT = 4'd10
   } state_t;

   typedef enum logic [2:0] {
      CLS_REG  = 3'd0,
      CLS_IMM  = 3'd1,
      CLS_LDI  = 3'd2,
      CLS_LD   = 3'd3,
      CLS_ST   = 3'd4,
      CLS_NOP  = 3'd5,
      CLS_HALT = 3'd6,
      CLS_ILL  = 3'd7
   } op_class_t;

   typedef struct packed {
      logic       run;
      logic       illegal_op;
      logic       pc_out;
      logic       pc_in;
      logic       inc_pc;
      logic       mar_in;
      logic       mdr_in;
      logic       mdr_out;
      logic       rd;
      logic       wr;
      logic       ir_in;
      logic       y_in;
      logic       z_in;
      logic       zlow_out;
      logic       gra;
      logic       grb;
      logic       grc;
      logic       r_in;
      logic       r_out;
      logic       ba_out;
      logic       c_out;
      logic [4:0] alu_select;
   } ctrl_t;

   function automatic op_class_t op_class(input logic [4:0] op);
      op_class_t cls;
      if (op == OP_LD) begin
         cls = CLS_LD;
      end else if (op == OP_LDI) begin
         cls = CLS_LDI;
      end else if (op == OP_ST) begin
         cls = CLS_ST;
      end else if ((op >= OP_ADD) && (op <= OP_OR)) begin
         cls = CLS_REG;
      end else if ((op >= OP_ADDI) && (op <= OP_ORI)) begin
         cls = CLS_IMM;
      end else if (op == OP_NOP) begin
         cls = CLS_NOP;
      end else if (op == OP_HALT) begin
         cls = CLS_HALT;
      end else begin
         cls = CLS_ILL;
      end
      return cls;
   endfunction

   // Register ALU ops pass the opcode straight through; everything else maps to a fixed code.
   function automatic logic [4:0] alu_code(input logic [4:0] op);
      logic [4:0] code;
      if ((op >= OP_ADD) && (op <= OP_OR)) begin
         code = op;
      end else if ((op == OP_ADDI) || (op == OP_LD) || (op == OP_LDI) || (op == OP_ST)) begin
         code = ALU_ADD;
      end else if (op == OP_ANDI) begin
         code = ALU_AND;
      end else if (op == OP_ORI) begin
         code = ALU_OR;
      end else begin
         code = ALU_NONE;
      end
      return code;
   endfunction

endpackage

// File: rtl/ctrl_decode.sv
// Combinational strobe decoder: maps the current T-state and opcode to the
// full datapath control bundle.
module ctrl_decode
   import cpu_ctrl_pkg::*;
(
   input  state_t     state,
   input  logic [4:0] opcode,
   output ctrl_t      ctrl
);

   op_class_t cls_s;

   assign cls_s = op_class(opcode);

   // Strobe table per T-state; RST and HALT leave everything at zero.
   always_comb begin
      ctrl = '0;
      case (state)
         ST_T0: begin
            ctrl.run    = 1'b1;
            ctrl.pc_out = 1'b1;
            ctrl.mar_in = 1'b1;
            ctrl.inc_pc = 1'b1;
            ctrl.z_in   = 1'b1;
         end
         ST_T1: begin
            ctrl.run      = 1'b1;
            ctrl.zlow_out = 1'b1;
            ctrl.pc_in    = 1'b1;
            ctrl.rd       = 1'b1;
            ctrl.mdr_in   = 1'b1;
         end
         ST_T1W: begin
            ctrl.run    = 1'b1;
            ctrl.rd     = 1'b1;
            ctrl.mdr_in = 1'b1;
         end
         ST_T2: begin
            ctrl.run     = 1'b1;
            ctrl.mdr_out = 1'b1;
            ctrl.ir_in   = 1'b1;
         end
         ST_T3: begin
            ctrl.run = 1'b1;
            case (cls_s)
               CLS_REG, CLS_IMM: begin
                  ctrl.grb   = 1'b1;
                  ctrl.r_out = 1'b1;
                  ctrl.y_in  = 1'b1;
               end
               CLS_LDI, CLS_LD, CLS_ST: begin
                  ctrl.grb    = 1'b1;
                  ctrl.ba_out = 1'b1;
                  ctrl.y_in   = 1'b1;
               end
               CLS_ILL: begin
                  ctrl.illegal_op = 1'b1;
               end
               default: begin
                  ctrl.illegal_op = 1'b0;
               end
            endcase
         end
         ST_T4: begin
            ctrl.run        = 1'b1;
            ctrl.z_in       = 1'b1;
            ctrl.alu_select = alu_code(opcode);
            if (cls_s == CLS_REG) begin
               ctrl.grc   = 1'b1;
               ctrl.r_out = 1'b1;
            end else begin
               ctrl.c_out = 1'b1;
            end
         end
         ST_T5: begin
            ctrl.run      = 1'b1;
            ctrl.zlow_out = 1'b1;
            if ((cls_s == CLS_LD) || (cls_s == CLS_ST)) begin
               ctrl.mar_in = 1'b1;
            end else begin
               ctrl.gra  = 1'b1;
               ctrl.r_in = 1'b1;
            end
         end
         ST_T6: begin
            ctrl.run    = 1'b1;
            ctrl.mdr_in = 1'b1;
            if (cls_s == CLS_ST) begin
               ctrl.gra   = 1'b1;
               ctrl.r_out = 1'b1;
            end else begin
               ctrl.rd = 1'b1;
            end
         end
         ST_T7: begin
            ctrl.run = 1'b1;
            if (cls_s == CLS_ST) begin
               ctrl.wr = 1'b1;
            end else begin
               ctrl.mdr_out = 1'b1;
               ctrl.gra     = 1'b1;
               ctrl.r_in    = 1'b1;
            end
         end
         default: begin
            ctrl = '0;
         end
      endcase
   end

endmodule

// File: rtl/ctrl_sequencer.sv
// Hardwired T-state control unit: state register, memory-wait counter with
// timeout, and the strobe outputs decoded from the current state.
module ctrl_sequencer
   import cpu_ctrl_pkg::*;
#(
   parameter int WAIT_LIMIT = 255
)
(
   input  logic        clk,
   input  logic        rst_n,
   input  logic [31:0] ir,
   input  logic        mem_ready,
   output logic        PCout,
   output logic        PC_in,
   output logic        Inc_PC,
   output logic        MAR_in,
   output logic        MDR_in,
   output logic        MDRout,
   output logic        read,
   output logic        write,
   output logic        IR_in,
   output logic        Y_in,
   output logic        Z_in,
   output logic        ZLOWout,
   output logic        gra,
   output logic        grb,
   output logic        grc,
   output logic        r_in,
   output logic        r_out,
   output logic        ba_out,
   output logic        c_out,
   output logic [4:0]  ALU_select,
   output logic        run,
   output logic        illegal_op,
   output logic        mem_timeout
);

   localparam int CW = $clog2(WAIT_LIMIT + 1);

   state_t          state_r;
   state_t          state_nxt_s;
   logic [CW-1:0]   wait_cnt_r;
   logic [CW-1:0]   wait_cnt_nxt_s;
   logic            mem_timeout_r;
   logic            waiting_s;
   logic            timeout_hit_s;
   logic [4:0]      opcode_s;
   op_class_t       cls_s;
   ctrl_t           ctrl_s;
   logic            unused_ir_fields;

   assign opcode_s = ir[OPC_HI:OPC_LO];
   assign cls_s    = op_class(opcode_s);

   // Register fields are consumed by the datapath's select-and-encode logic, not here.
   assign unused_ir_fields = ^{ir[RA_HI:RA_LO], ir[RB_HI:RB_LO], ir[RC_HI:RC_LO], ir[C_HI:C_LO]};

   // Wait accounting and next-state selection.
   always_comb begin
      waiting_s = 1'b0;
      case (state_r)
         ST_T1W:  waiting_s = 1'b1;
         ST_T6:   waiting_s = (cls_s == CLS_LD);
         ST_T7:   waiting_s = (cls_s == CLS_ST);
         default: waiting_s = 1'b0;
      endcase

      timeout_hit_s  = waiting_s && !mem_ready && (wait_cnt_r == CW'(WAIT_LIMIT - 1));
      wait_cnt_nxt_s = (waiting_s && !mem_ready) ? (wait_cnt_r + CW'(1)) : '0;

      state_nxt_s = state_r;
      case (state_r)
         ST_RST:  state_nxt_s = ST_T0;
         ST_T0:   state_nxt_s = ST_T1;
         ST_T1:   state_nxt_s = mem_ready ? ST_T2 : ST_T1W;
         ST_T1W:  state_nxt_s = mem_ready ? ST_T2 : (timeout_hit_s ? ST_HALT : ST_T1W);
         ST_T2:   state_nxt_s = ST_T3;
         ST_T3: begin
            case (cls_s)
               CLS_HALT:         state_nxt_s = ST_HALT;
               CLS_NOP, CLS_ILL: state_nxt_s = ST_T0;
               default:          state_nxt_s = ST_T4;
            endcase
         end
         ST_T4:   state_nxt_s = ST_T5;
         ST_T5:   state_nxt_s = ((cls_s == CLS_LD) || (cls_s == CLS_ST)) ? ST_T6 : ST_T0;
         ST_T6: begin
            if (cls_s == CLS_LD) begin
               state_nxt_s = mem_ready ? ST_T7 : (timeout_hit_s ? ST_HALT : ST_T6);
            end else begin
               state_nxt_s = ST_T7;
            end
         end
         ST_T7: begin
            if (cls_s == CLS_ST) begin
               state_nxt_s = mem_ready ? ST_T0 : (timeout_hit_s ? ST_HALT : ST_T7);
            end else begin
               state_nxt_s = ST_T0;
            end
         end
         ST_HALT: state_nxt_s = ST_HALT;
         default: state_nxt_s = ST_RST;
      endcase
   end

   // State, wait counter and sticky timeout flag.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_r       <= ST_RST;
         wait_cnt_r    <= '0;
         mem_timeout_r <= 1'b0;
      end else begin
         state_r       <= state_nxt_s;
         wait_cnt_r    <= wait_cnt_nxt_s;
         mem_timeout_r <= mem_timeout_r | timeout_hit_s;
      end
   end

   ctrl_decode u_decode (
      .state  (state_r),
      .opcode (opcode_s),
      .ctrl   (ctrl_s)
   );

   assign run         = ctrl_s.run;
   assign illegal_op  = ctrl_s.illegal_op;
   assign PCout       = ctrl_s.pc_out;
   assign PC_in       = ctrl_s.pc_in;
   assign Inc_PC      = ctrl_s.inc_pc;
   assign MAR_in      = ctrl_s.mar_in;
   assign MDR_in      = ctrl_s.mdr_in;
   assign MDRout      = ctrl_s.mdr_out;
   assign read        = ctrl_s.rd;
   assign write       = ctrl_s.wr;
   assign IR_in       = ctrl_s.ir_in;
   assign Y_in        = ctrl_s.y_in;
   assign Z_in        = ctrl_s.z_in;
   assign ZLOWout     = ctrl_s.zlow_out;
   assign gra         = ctrl_s.gra;
   assign grb         = ctrl_s.grb;
   assign grc         = ctrl_s.grc;
   assign r_in        = ctrl_s.r_in;
   assign r_out       = ctrl_s.r_out;
   assign ba_out      = ctrl_s.ba_out;
   assign c_out       = ctrl_s.c_out;
   assign ALU_select  = ctrl_s.alu_select;
   assign mem_timeout = mem_timeout_r;

endmodule

// File: tb/tb_ctrl_sequencer.sv
// Self-checking bench for ctrl_sequencer: per-instruction strobe tables with
// randomized memory stalls, plus halt, illegal, reset and timeout scenarios.
module tb_ctrl_sequencer;

   localparam int WL = 255;

   localparam logic [20:0] M_RUN   = 21'd1 << 20;
   localparam logic [20:0] M_ILL   = 21'd1 << 19;
   localparam logic [20:0] M_PCOUT = 21'd1 << 18;
   localparam logic [20:0] M_PCIN  = 21'd1 << 17;
   localparam logic [20:0] M_INCPC = 21'd1 << 16;
   localparam logic [20:0] M_MARIN = 21'd1 << 15;
   localparam logic [20:0] M_MDRIN = 21'd1 << 14;
   localparam logic [20:0] M_MDROUT= 21'd1 << 13;
   localparam logic [20:0] M_READ  = 21'd1 << 12;
   localparam logic [20:0] M_WRITE = 21'd1 << 11;
   localparam logic [20:0] M_IRIN  = 21'd1 << 10;
   localparam logic [20:0] M_YIN   = 21'd1 << 9;
   localparam logic [20:0] M_ZIN   = 21'd1 << 8;
   localparam logic [20:0] M_ZLOW  = 21'd1 << 7;
   localparam logic [20:0] M_GRA   = 21'd1 << 6;
   localparam logic [20:0] M_GRB   = 21'd1 << 5;
   localparam logic [20:0] M_GRC   = 21'd1 << 4;
   localparam logic [20:0] M_RIN   = 21'd1 << 3;
   localparam logic [20:0] M_ROUT  = 21'd1 << 2;
   localparam logic [20:0] M_BAOUT = 21'd1 << 1;
   localparam logic [20:0] M_COUT  = 21'd1 << 0;

   logic        clk, rst_n, mem_ready;
   logic [31:0] ir;
   logic        PCout, PC_in, Inc_PC, MAR_in, MDR_in, MDRout, read, write, IR_in;
   logic        Y_in, Z_in, ZLOWout, gra, grb, grc, r_in, r_out, ba_out, c_out;
   logic [4:0]  ALU_select;
   logic        run, illegal_op, mem_timeout;
   logic [20:0] obs;

   int checks = 0;
   int failures = 0;

   typedef struct packed {
      logic [20:0] s;
      logic [20:0] ws;
      logic [4:0]  alu;
      logic        wt;
   } step_t;

   step_t plan[$];

   ctrl_sequencer #(.WAIT_LIMIT(WL)) dut (
      .clk(clk), .rst_n(rst_n), .ir(ir), .mem_ready(mem_ready),
      .PCout(PCout), .PC_in(PC_in), .Inc_PC(Inc_PC), .MAR_in(MAR_in), .MDR_in(MDR_in),
      .MDRout(MDRout), .read(read), .write(write), .IR_in(IR_in), .Y_in(Y_in), .Z_in(Z_in),
      .ZLOWout(ZLOWout), .gra(gra), .grb(grb), .grc(grc), .r_in(r_in), .r_out(r_out),
      .ba_out(ba_out), .c_out(c_out), .ALU_select(ALU_select), .run(run),
      .illegal_op(illegal_op), .mem_timeout(mem_timeout)
   );

   assign obs = {run, illegal_op, PCout, PC_in, Inc_PC, MAR_in, MDR_in, MDRout, read, write,
                 IR_in, Y_in, Z_in, ZLOWout, gra, grb, grc, r_in, r_out, ba_out, c_out};

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1);
   end

   task automatic push(input logic [20:0] s, input logic [4:0] alu, input logic wt, input logic [20:0] ws);
      step_t st;
      st.s = s; st.ws = ws; st.alu = alu; st.wt = wt;
      plan.push_back(st);
   endtask

   // Expected per-cycle strobes for one instruction, straight from the control tables.
   task automatic build_plan(input logic [4:0] op);
      logic [4:0] alu;
      plan.delete();
      push(M_RUN | M_PCOUT | M_MARIN | M_INCPC | M_ZIN, 5'd0, 1'b0, M_RUN | M_PCOUT | M_MARIN | M_INCPC | M_ZIN);
      push(M_RUN | M_ZLOW | M_PCIN | M_READ | M_MDRIN, 5'd0, 1'b1, M_RUN | M_READ | M_MDRIN);
      push(M_RUN | M_MDROUT | M_IRIN, 5'd0, 1'b0, M_RUN | M_MDROUT | M_IRIN);
      if (op >= 5'd3 && op <= 5'd13) begin
         alu = (op == 5'd11) ? 5'd3 : (op == 5'd12) ? 5'd9 : (op == 5'd13) ? 5'd10 : op;
         push(M_RUN | M_GRB | M_ROUT | M_YIN, 5'd0, 1'b0, M_RUN | M_GRB | M_ROUT | M_YIN);
         push(M_RUN | M_ZIN | ((op >= 5'd11) ? M_COUT : (M_GRC | M_ROUT)), alu, 1'b0,
              M_RUN | M_ZIN | ((op >= 5'd11) ? M_COUT : (M_GRC | M_ROUT)));
         push(M_RUN | M_ZLOW | M_GRA | M_RIN, 5'd0, 1'b0, M_RUN | M_ZLOW | M_GRA | M_RIN);
      end else if (op <= 5'd2) begin
         push(M_RUN | M_GRB | M_BAOUT | M_YIN, 5'd0, 1'b0, M_RUN | M_GRB | M_BAOUT | M_YIN);
         push(M_RUN | M_COUT | M_ZIN, 5'd3, 1'b0, M_RUN | M_COUT | M_ZIN);
         if (op == 5'd1) begin
            push(M_RUN | M_ZLOW | M_GRA | M_RIN, 5'd0, 1'b0, M_RUN | M_ZLOW | M_GRA | M_RIN);
         end else begin
            push(M_RUN | M_ZLOW | M_MARIN, 5'd0, 1'b0, M_RUN | M_ZLOW | M_MARIN);
            if (op == 5'd0) begin
               push(M_RUN | M_READ | M_MDRIN, 5'd0, 1'b1, M_RUN | M_READ | M_MDRIN);
               push(M_RUN | M_MDROUT | M_GRA | M_RIN, 5'd0, 1'b0, M_RUN | M_MDROUT | M_GRA | M_RIN);
            end else begin
               push(M_RUN | M_GRA | M_ROUT | M_MDRIN, 5'd0, 1'b0, M_RUN | M_GRA | M_ROUT | M_MDRIN);
               push(M_RUN | M_WRITE, 5'd0, 1'b1, M_RUN | M_WRITE);
            end
         end
      end else if (op == 5'd26 || op == 5'd27) begin
         push(M_RUN, 5'd0, 1'b0, M_RUN);
      end else begin
         push(M_RUN | M_ILL, 5'd0, 1'b0, M_RUN | M_ILL);
      end
   endtask

   // Runs one instruction from T0; stall < 0 picks a random stall length.
   task automatic exec(input logic [31:0] iv, input int fstall, input int dstall);
      logic [4:0]  op;
      logic [20:0] exp_s;
      int cycles, lows, left, base;
      bit first, again;
      op = iv[31:27];
      build_plan(op);
      cycles = 0;
      lows = 0;
      for (int k = 0; k < plan.size(); k++) begin
         left = 0;
         if (plan[k].wt) begin
            if (k == 1) left = (fstall < 0) ? int'($urandom_range(0, 4)) : fstall;
            else        left = (dstall < 0) ? int'($urandom_range(0, 4)) : dstall;
         end
         first = 1'b1;
         again = 1'b1;
         while (again) begin
            @(negedge clk);
            cycles++;
            exp_s = first ? plan[k].s : plan[k].ws;
            checks++;
            if (obs !== exp_s || ALU_select !== plan[k].alu) begin
               failures++;
               $display("FAIL strobes op=%b step=%0d got=%h/%b want=%h/%b", op, k, obs, ALU_select, exp_s, plan[k].alu);
            end
            if (k == 0) ir = iv;
            first = 1'b0;
            if (left > 0) begin
               mem_ready = 1'b0;
               left--;
               lows++;
            end else begin
               mem_ready = plan[k].wt ? 1'b1 : 1'($urandom_range(0, 1));
               again = 1'b0;
            end
         end
      end
      if (op != 5'd27) begin
         base = (op == 5'd0 || op == 5'd2) ? 8 : ((op >= 5'd1 && op <= 5'd13) ? 6 : 4);
         checks++;
         if (cycles !== base + lows) begin
            failures++;
            $display("FAIL latency op=%b got=%0d want=%0d", op, cycles, base + lows);
         end
      end
   endtask

   task automatic do_reset();
      #2 rst_n = 1'b0;
      #1;
      checks++;
      if (obs !== 21'd0 || ALU_select !== 5'd0 || mem_timeout !== 1'b0) begin
         failures++;
         $display("FAIL reset_assert got=%h/%b/%b want=0", obs, ALU_select, mem_timeout);
      end
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      #1;
      checks++;
      if (obs !== 21'd0) begin
         failures++;
         $display("FAIL reset_rst_state got=%h want=0", obs);
      end
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      mem_ready = 1'b1;
      ir = 32'hD0000000;
      #1;
      checks++;
      if (obs !== 21'd0 || ALU_select !== 5'd0 || mem_timeout !== 1'b0) begin
         failures++;
         $display("FAIL reset_init got=%h/%b/%b want=0", obs, ALU_select, mem_timeout);
      end
      do_reset();
   endtask

   task automatic test_plan_cases();
      exec(32'h4A920000, 0, 0);   // and R5,R2,R4
      exec(32'h18000000, 3, 0);   // add with fetch stall
      exec(32'h00800055, 0, 0);   // ld R1,0x55(R0)
      exec(32'h10800055, 0, 2);   // st with write stall
      exec(32'h00800055, 2, 3);   // ld with read stall
      exec(32'h68000000, 0, 0);   // ori
   endtask

   task automatic test_illegal();
      exec(32'hF8000000, 0, 0);
      exec(32'hD0000000, 0, 0);
      exec(32'h70000000, 1, 0);
   endtask

   task automatic test_back_to_back();
      logic [4:0] op;
      for (int i = 0; i < 50; i++) begin
         do op = 5'($urandom_range(0, 31)); while (op == 5'd27);
         exec({op, 27'($urandom)}, -1, -1);
      end
   endtask

   task automatic test_halt();
      exec(32'hD8000000, 0, 0);
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         mem_ready = 1'($urandom_range(0, 1));
         checks++;
         if (obs !== 21'd0 || ALU_select !== 5'd0) begin
            failures++;
            $display("FAIL halt_idle cycle=%0d got=%h want=0", i, obs);
         end
      end
      do_reset();
      exec(32'h58000000, 0, 0);
   endtask

   task automatic test_reset_mid_wait();
      for (int i = 0; i < 6; i++) begin
         @(negedge clk);
         if (i == 0) ir = 32'h00800055;
         mem_ready = 1'b1;
      end
      for (int i = 0; i < 2; i++) begin
         @(negedge clk);
         mem_ready = 1'b0;
         checks++;
         if (obs !== (M_RUN | M_READ | M_MDRIN)) begin
            failures++;
            $display("FAIL t6_wait got=%h want=%h", obs, M_RUN | M_READ | M_MDRIN);
         end
      end
      do_reset();
      exec(32'h08000000, 0, 0);
   endtask

   task automatic test_timeout();
      int n;
      bit done;
      n = 0;
      done = 1'b0;
      ir = 32'hD0000000;
      while (!done && n < WL + 20) begin
         @(negedge clk);
         mem_ready = 1'b0;
         n++;
         if (n == WL) begin
            checks++;
            if (mem_timeout !== 1'b0 || run !== 1'b1) begin
               failures++;
               $display("FAIL timeout_early n=%0d mem_timeout=%b run=%b want 0/1", n, mem_timeout, run);
            end
         end
         if (run === 1'b0) done = 1'b1;
      end
      checks++;
      if (!done || n < WL + 2 || mem_timeout !== 1'b1 || obs !== 21'd0) begin
         failures++;
         $display("FAIL timeout got done=%b n=%0d mem_timeout=%b obs=%h want done=1 n>=%0d 1 0", done, n, mem_timeout, obs, WL + 2);
      end
      repeat (5) begin
         @(negedge clk);
         mem_ready = 1'b1;
      end
      checks++;
      if (mem_timeout !== 1'b1 || run !== 1'b0) begin
         failures++;
         $display("FAIL timeout_sticky got=%b/%b want=1/0", mem_timeout, run);
      end
      do_reset();
      exec(32'h60000000, 0, 0);
   endtask

   initial begin
      test_reset();
      test_plan_cases();
      test_illegal();
      test_back_to_back();
      test_halt();
      test_reset_mid_wait();
      test_timeout();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/ctrl_sequencer.md
# ctrl_sequencer

Hardwired control unit for the 32-bit bus-based CPU datapath. It generates, each cycle, the register-transfer strobes consumed by `datapath`: PCout, MAR_in, Inc_PC, read, MDR_in, IR_in, Y_in, Z_in, ZLOWout and the register select lines. It runs the fetch cycle, decodes IR, and executes ALU, immediate, load and store instructions as a T-state machine. It replaces the hand-driven control sequences used for datapath bring-up.

## Interface
Parameters:
- `WAIT_LIMIT`, 255: maximum number of cycles the sequencer waits for `mem_ready` before asserting `mem_timeout`.

Ports:
- `clk` in 1: single clock, rising edge.
- `rst_n` in 1: reset, asynchronous and active-low.
- `ir` in 32: IR contents from the datapath. Fields: opcode [31:27], ra [26:23], rb [22:19], rc [18:15], C [18:0].
- `mem_ready` in 1: memory completed the current read or write this cycle.
- `PCout`, `PC_in`, `Inc_PC`, `MAR_in`, `MDR_in`, `MDRout`, `read`, `write`, `IR_in`, `Y_in`, `Z_in`, `ZLOWout` out 1 each: datapath strobes.
- `gra`, `grb`, `grc`, `r_in`, `r_out`, `ba_out`, `c_out` out 1 each: select-and-encode controls.
- `ALU_select` out 5: ALU operation code.
- `run` out 1: high while executing, low in HALT.
- `illegal_op` out 1: one-cycle pulse on an unsupported opcode.
- `mem_timeout` out 1: sticky error flag, cleared only by reset.

## Operation
- States: RST, T0, T1, T1W, T2, T3, T4, T5, T6, T7, HALT.
- Outputs are decoded combinationally from the state. In T3–T7 they also depend on `ir`, which is valid from T3 onward.
- Opcodes:
  - ld 00000, ldi 00001, st 00010.
  - Register ALU ops add 00011 through or 01010.
  - addi 01011, andi 01100, ori 01101.
  - nop 11010, halt 11011.
  - All other opcodes are illegal.
- ALU_select:
  - Equals the opcode for register ALU ops.
  - addi, ld, ldi and st use 00011 (add).
  - andi uses 01001; ori uses 01010.
  - Outside T4 it is 00000.
- Fetch sequence:
  - T0: PCout, MAR_in, Inc_PC, Z_in.
  - T1: ZLOWout, PC_in, read, MDR_in.
  - T1W: read and MDR_in only; repeats until `mem_ready` is high.
  - T2: MDRout, IR_in.
- Register ALU ops:
  - T3: grb, r_out, Y_in.
  - T4: grc, r_out, Z_in.
  - T5: ZLOWout, gra, r_in. Next state is T0.
- Immediate ops: same as register ALU ops, except T4 asserts c_out instead of grc/r_out.
- ldi:
  - T3: grb, ba_out, Y_in.
  - T4: c_out, Z_in.
  - T5: ZLOWout, gra, r_in. Next state is T0.
- ld:
  - T3–T4 as ldi.
  - T5: ZLOWout, MAR_in.
  - T6: read, MDR_in; holds until `mem_ready`.
  - T7: MDRout, gra, r_in. Next state is T0.
- st:
  - T3–T5 as ld.
  - T6: gra, r_out, MDR_in (read low).
  - T7: write; holds until `mem_ready`.
- nop: T3 asserts nothing; next state is T0.
- halt: T3 goes to HALT. In HALT `run`=0 and all strobes are 0. Only reset leaves HALT.
- Illegal opcode: T3 pulses `illegal_op`; next state is T0 (executes as nop).
- Memory wait timeout:
  - A wait counter runs in T1W, T6 (ld) and T7 (st). It clears whenever `mem_ready` is seen.
  - On reaching WAIT_LIMIT: set `mem_timeout`, go to HALT.

## Timing
- Reset: all outputs are 0 immediately (asynchronous), the state is RST and the wait counter is 0.
- First rising edge after `rst_n` goes high: RST→T0. `run`=1 from T0.
- Latency with `mem_ready` always high:
  - ALU, immediate and ldi instructions: 6 cycles (T0–T5).
  - ld and st: 8 cycles.
  - nop and illegal opcodes: 4 cycles.
- Each memory wait cycle adds 1 cycle.
- `mem_ready` is sampled at the rising edge that ends T1, T1W, T6 (ld) and T7 (st). When `mem_ready` is high at that edge the state advances; otherwise the read/write strobes stay asserted.
- PC_in and ZLOWout are asserted for exactly one cycle per fetch, regardless of wait length.
- Reset asserted in any state, including mid-wait, aborts the transaction with no further strobes.
- `illegal_op` is high for exactly the T3 cycle.

## Structure
- Package `cpu_ctrl_pkg` holds the opcode constants, the ALU_select codes, the state encoding and the IR field bit positions.
- Sub-module `ctrl_decode`: purely combinational map from (state, opcode) to all strobes and ALU_select.
- `ctrl_sequencer` holds the state register, next-state logic, wait counter and error flags.

## Test plan
- **and R5,R2,R4:** ir=32'h4A920000, mem_ready=1.
  - T3: grb, r_out, Y_in.
  - T4: grc, r_out, Z_in, ALU_select=01001.
  - T5: gra, r_in, ZLOWout.
  - T0 reached on the 7th cycle.
- **Fetch stall:** mem_ready low for 3 cycles in fetch. read and MDR_in are high for 4 cycles; PC_in is high for 1 cycle; total latency is 9 cycles.
- **ld R1,0x55(R0):** ir=32'h00800055.
  - T3: ba_out.
  - T4: c_out, ALU_select=00011.
  - T5: MAR_in.
  - T7: MDRout, gra, r_in.
  - 8 cycles total.
- **st with write stall:** mem_ready low 2 cycles in T7. write is held for 3 cycles, then T0.
- **halt and illegal opcode:**
  - ir=32'hD8000000 (halt): run falls after T3 and stays low for 20 cycles; reset restores run=1.
  - ir=32'hF8000000 (illegal): one illegal_op pulse, then T0.
- **Reset and timeout:**
  - rst_n pulled low during a T6 wait: all strobes are 0 asynchronously; restart goes through RST→T0.
  - mem_ready held low for WAIT_LIMIT cycles: mem_timeout=1 and run=0.
